// File: rtl/pe_weight_port_arbiter.sv
// rtl/pe_weight_port_arbiter.sv - weight namespace write/read port arbiter
// Memory loads beat core write-backs; losing core writes wait in a pending FIFO flushed on eoc.
module pe_weight_port_arbiter #(
    parameter int peId             = 0,
    parameter int logNumPe         = 3,
    parameter int logNumPu         = 3,
    parameter int logNumPeMemLanes = 2,
    parameter int weightAddrLen    = 5,
    parameter int dataLen          = 16,
    parameter int pendDepthLog     = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        eoc,
    input  logic                        mem_weight_wrt,
    input  logic [weightAddrLen-1:0]    mem_weight_wrt_addr,
    input  logic [dataLen-1:0]          mem_weight_wrt_data,
    input  logic                        core_weight_wrt,
    input  logic [weightAddrLen-1:0]    core_weight_wrt_addr,
    input  logic [dataLen-1:0]          core_weight_wrt_data,
    output logic                        core_weight_stall,
    input  logic                        mem_weight_rd_valid,
    input  logic [logNumPeMemLanes-1:0] peId_mem_in,
    input  logic [weightAddrLen-1:0]    weight_read_back_addr,
    input  logic [weightAddrLen-1:0]    core_weight_rd_addr,
    output logic                        ns_weight_wrt,
    output logic [weightAddrLen-1:0]    ns_weight_wrt_addr,
    output logic [dataLen-1:0]          ns_weight_wrt_data,
    output logic [weightAddrLen-1:0]    ns_weight_rd_addr,
    output logic                        readback_v,
    output logic                        core_rd_blocked,
    output logic                        core_rd_hazard,
    output logic [pendDepthLog:0]       pend_count,
    output logic                        overflow_err,
    output logic                        flush_done
);

    localparam int DEPTH = 1 << pendDepthLog;
    localparam int LANE_HI = logNumPe + logNumPu - 1;
    localparam logic [31:0] PE_ID = peId;
    localparam logic [logNumPeMemLanes-1:0] MY_LANE = PE_ID[LANE_HI -: logNumPeMemLanes];
    localparam logic [pendDepthLog:0] FULL_CNT = (pendDepthLog+1)'(DEPTH);

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t state, state_next;
    logic [weightAddrLen-1:0] fifo_addr [DEPTH];
    logic [dataLen-1:0]       fifo_data [DEPTH];
    logic [pendDepthLog-1:0]  wr_ptr, rd_ptr;
    logic [pendDepthLog:0]    count;
    logic empty, full, deq, direct, enq_req, enq, drop, lane_hit;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    // A core write only bypasses the FIFO when nothing older could be ahead of it.
    always_comb begin
        deq     = !mem_weight_wrt && !empty;
        direct  = core_weight_wrt && !mem_weight_wrt && empty;
        enq_req = core_weight_wrt && !direct;
        enq     = enq_req && !full;
        drop    = enq_req && full;
    end

    always_comb begin
        ns_weight_wrt      = 1'b0;
        ns_weight_wrt_addr = mem_weight_wrt_addr;
        ns_weight_wrt_data = mem_weight_wrt_data;
        if (mem_weight_wrt) begin
            ns_weight_wrt = 1'b1;
        end else if (!empty) begin
            ns_weight_wrt      = 1'b1;
            ns_weight_wrt_addr = fifo_addr[rd_ptr];
            ns_weight_wrt_data = fifo_data[rd_ptr];
        end else if (core_weight_wrt) begin
            ns_weight_wrt      = 1'b1;
            ns_weight_wrt_addr = core_weight_wrt_addr;
            ns_weight_wrt_data = core_weight_wrt_data;
        end
    end

    always_comb begin
        core_rd_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((pendDepthLog+1)'(i) < count &&
                fifo_addr[rd_ptr + pendDepthLog'(i)] == core_weight_rd_addr)
                core_rd_hazard = 1'b1;
        end
    end

    assign lane_hit          = mem_weight_rd_valid && (peId_mem_in == MY_LANE);
    assign ns_weight_rd_addr = lane_hit ? weight_read_back_addr : core_weight_rd_addr;
    assign core_rd_blocked   = lane_hit;
    assign core_weight_stall = full || (state != RUN);
    assign pend_count        = count;
    assign flush_done        = (state == DONE);

    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_addr[wr_ptr] <= core_weight_wrt_addr;
            fifo_data[wr_ptr] <= core_weight_wrt_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            readback_v   <= 1'b0;
            overflow_err <= 1'b0;
            state        <= RUN;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            if (enq && !deq)      count <= count + 1'b1;
            else if (deq && !enq) count <= count - 1'b1;
            readback_v <= lane_hit;
            if (drop) overflow_err <= 1'b1;
            state <= state_next;
        end
    end

    // Emptiness is judged on the registered count, so an empty FIFO still spends one DRAIN cycle.
    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (eoc) state_next = DRAIN;
            DRAIN:   if (empty) state_next = DONE;
            DONE:    state_next = RUN;
            default: state_next = RUN;
        endcase
    end

endmodule

// File: tb/tb_pe_weight_port_arbiter.sv
// tb/tb_pe_weight_port_arbiter.sv - directed vector bench for pe_weight_port_arbiter
module tb_pe_weight_port_arbiter;

    logic        clk = 1'b0;
    logic        reset, eoc;
    logic        mem_weight_wrt, core_weight_wrt, mem_weight_rd_valid;
    logic [4:0]  mem_weight_wrt_addr, core_weight_wrt_addr, weight_read_back_addr, core_weight_rd_addr;
    logic [15:0] mem_weight_wrt_data, core_weight_wrt_data;
    logic [1:0]  peId_mem_in;
    logic        core_weight_stall, ns_weight_wrt, readback_v, core_rd_blocked, core_rd_hazard;
    logic        overflow_err, flush_done;
    logic [4:0]  ns_weight_wrt_addr, ns_weight_rd_addr;
    logic [15:0] ns_weight_wrt_data;
    logic [2:0]  pend_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pe_weight_port_arbiter #(.peId(8)) dut (
        .clk(clk), .reset(reset), .eoc(eoc),
        .mem_weight_wrt(mem_weight_wrt), .mem_weight_wrt_addr(mem_weight_wrt_addr),
        .mem_weight_wrt_data(mem_weight_wrt_data),
        .core_weight_wrt(core_weight_wrt), .core_weight_wrt_addr(core_weight_wrt_addr),
        .core_weight_wrt_data(core_weight_wrt_data), .core_weight_stall(core_weight_stall),
        .mem_weight_rd_valid(mem_weight_rd_valid), .peId_mem_in(peId_mem_in),
        .weight_read_back_addr(weight_read_back_addr), .core_weight_rd_addr(core_weight_rd_addr),
        .ns_weight_wrt(ns_weight_wrt), .ns_weight_wrt_addr(ns_weight_wrt_addr),
        .ns_weight_wrt_data(ns_weight_wrt_data), .ns_weight_rd_addr(ns_weight_rd_addr),
        .readback_v(readback_v), .core_rd_blocked(core_rd_blocked), .core_rd_hazard(core_rd_hazard),
        .pend_count(pend_count), .overflow_err(overflow_err), .flush_done(flush_done)
    );

    typedef struct {
        logic mw; logic [4:0] ma; logic [15:0] md;
        logic cw; logic [4:0] ca; logic [15:0] cd;
        logic rv; logic [1:0] lane; logic [4:0] rba; logic [4:0] cra;
        logic e_w; logic [4:0] e_a; logic [15:0] e_d; logic [4:0] e_ra;
        logic e_blk; logic e_rbv; logic e_hz; logic [2:0] e_pc;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        eoc = 0; mem_weight_wrt = 0; mem_weight_wrt_addr = 0; mem_weight_wrt_data = 0;
        core_weight_wrt = 0; core_weight_wrt_addr = 0; core_weight_wrt_data = 0;
        mem_weight_rd_valid = 0; peId_mem_in = 0; weight_read_back_addr = 0; core_weight_rd_addr = 0;
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    // mem write held high for n cycles, each losing core write enqueued at base+k
    task automatic load_pending(input int n, input int base);
        for (int k = 0; k < n; k++) begin
            cyc();
            mem_weight_wrt = 1; mem_weight_wrt_addr = 5'(k);
            core_weight_wrt = 1; core_weight_wrt_addr = 5'(base + k);
            core_weight_wrt_data = 16'(16'h200 + k);
        end
    endtask

    initial begin
        int stall_at, nw, flushes, flush_at, stall_low, bad_w;

        vecs[0] = '{1'b0, 5'd0, 16'h0,    1'b1, 5'd3, 16'h00AA, 1'b0, 2'd0, 5'd0, 5'd0, 1'b1, 5'd3, 16'h00AA, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[1] = '{1'b1, 5'd1, 16'h0011, 1'b1, 5'd2, 16'h0022, 1'b0, 2'd0, 5'd0, 5'd0, 1'b1, 5'd1, 16'h0011, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[2] = '{1'b0, 5'd0, 16'h0,    1'b0, 5'd0, 16'h0,    1'b0, 2'd0, 5'd0, 5'd0, 1'b1, 5'd2, 16'h0022, 5'd0, 1'b0, 1'b0, 1'b0, 3'd1};
        vecs[3] = '{1'b0, 5'd0, 16'h0,    1'b0, 5'd0, 16'h0,    1'b0, 2'd0, 5'd0, 5'd0, 1'b0, 5'd0, 16'h0,    5'd0, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[4] = '{1'b0, 5'd0, 16'h0,    1'b0, 5'd0, 16'h0,    1'b1, 2'd0, 5'd7, 5'd4, 1'b0, 5'd0, 16'h0,    5'd7, 1'b1, 1'b0, 1'b0, 3'd0};
        vecs[5] = '{1'b0, 5'd0, 16'h0,    1'b0, 5'd0, 16'h0,    1'b1, 2'd1, 5'd7, 5'd4, 1'b0, 5'd0, 16'h0,    5'd4, 1'b0, 1'b1, 1'b0, 3'd0};
        vecs[6] = '{1'b0, 5'd0, 16'h0,    1'b0, 5'd0, 16'h0,    1'b0, 2'd0, 5'd0, 5'd4, 1'b0, 5'd0, 16'h0,    5'd4, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[7] = '{1'b1, 5'd9, 16'h0099, 1'b1, 5'd5, 16'h0055, 1'b0, 2'd0, 5'd0, 5'd5, 1'b1, 5'd9, 16'h0099, 5'd5, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[8] = '{1'b0, 5'd0, 16'h0,    1'b0, 5'd0, 16'h0,    1'b0, 2'd0, 5'd0, 5'd5, 1'b1, 5'd5, 16'h0055, 5'd5, 1'b0, 1'b0, 1'b1, 3'd1};
        vecs[9] = '{1'b0, 5'd0, 16'h0,    1'b0, 5'd0, 16'h0,    1'b0, 2'd0, 5'd0, 5'd5, 1'b0, 5'd0, 16'h0,    5'd5, 1'b0, 1'b0, 1'b0, 3'd0};

        idle(); reset = 1;
        cyc(); cyc(); reset = 0; #1;
        chk("reset_pend_count", 32'(pend_count), 0);
        chk("reset_overflow", 32'(overflow_err), 0);
        chk("reset_flush_done", 32'(flush_done), 0);
        chk("reset_readback_v", 32'(readback_v), 0);
        chk("reset_stall", 32'(core_weight_stall), 0);

        for (int i = 0; i < 10; i++) begin
            cyc();
            mem_weight_wrt = vecs[i].mw; mem_weight_wrt_addr = vecs[i].ma; mem_weight_wrt_data = vecs[i].md;
            core_weight_wrt = vecs[i].cw; core_weight_wrt_addr = vecs[i].ca; core_weight_wrt_data = vecs[i].cd;
            mem_weight_rd_valid = vecs[i].rv; peId_mem_in = vecs[i].lane;
            weight_read_back_addr = vecs[i].rba; core_weight_rd_addr = vecs[i].cra;
            #1;
            chk($sformatf("v%0d_ns_wrt", i), 32'(ns_weight_wrt), 32'(vecs[i].e_w));
            if (vecs[i].e_w) begin
                chk($sformatf("v%0d_ns_addr", i), 32'(ns_weight_wrt_addr), 32'(vecs[i].e_a));
                chk($sformatf("v%0d_ns_data", i), 32'(ns_weight_wrt_data), 32'(vecs[i].e_d));
            end
            chk($sformatf("v%0d_rd_addr", i), 32'(ns_weight_rd_addr), 32'(vecs[i].e_ra));
            chk($sformatf("v%0d_blocked", i), 32'(core_rd_blocked), 32'(vecs[i].e_blk));
            chk($sformatf("v%0d_readback_v", i), 32'(readback_v), 32'(vecs[i].e_rbv));
            chk($sformatf("v%0d_hazard", i), 32'(core_rd_hazard), 32'(vecs[i].e_hz));
            chk($sformatf("v%0d_pend_count", i), 32'(pend_count), 32'(vecs[i].e_pc));
        end

        // Fill under a long mem write, then with stall ignored
        for (int pass = 0; pass < 2; pass++) begin
            idle(); stall_at = -1;
            for (int k = 0; k < 6; k++) begin
                cyc();
                if (core_weight_stall && stall_at < 0) stall_at = k;
                mem_weight_wrt = 1; mem_weight_wrt_addr = 5'(20 + k); mem_weight_wrt_data = 16'h0;
                core_weight_wrt = (pass == 1) ? 1'b1 : !core_weight_stall;
                core_weight_wrt_addr = 5'(10 + k); core_weight_wrt_data = 16'(16'h100 + k);
            end
            cyc(); idle();
            if (pass == 0) chk("fill_stall_at", 32'(stall_at), 4);
            chk($sformatf("p%0d_overflow", pass), 32'(overflow_err), 32'(pass));
            chk($sformatf("p%0d_pend_full", pass), 32'(pend_count), 4);
            for (int i = 0; i < 4; i++) begin
                #1;
                chk($sformatf("p%0d_drain%0d_wrt", pass, i), 32'(ns_weight_wrt), 1);
                chk($sformatf("p%0d_drain%0d_addr", pass, i), 32'(ns_weight_wrt_addr), 32'(10 + i));
                chk($sformatf("p%0d_drain%0d_data", pass, i), 32'(ns_weight_wrt_data), 32'(16'h100 + i));
                cyc();
            end
            chk($sformatf("p%0d_pend_empty", pass), 32'(pend_count), 0);
        end

        // Three pending entries then eoc
        idle(); reset = 1; cyc(); reset = 0;
        load_pending(3, 16);
        cyc(); core_weight_wrt = 0; eoc = 1; mem_weight_wrt_addr = 5'd30;
        nw = 0; flushes = 0; flush_at = -1; stall_low = 0; bad_w = 0;
        for (int j = 1; j <= 8; j++) begin
            cyc(); idle(); #1;
            if (j <= 5 && !core_weight_stall) stall_low++;
            if (ns_weight_wrt) begin
                if (ns_weight_wrt_addr != 5'(16 + nw) || j > 3) bad_w++;
                nw++;
            end
            if (flush_done) begin
                flushes++;
                if (flush_at < 0) flush_at = j;
            end
        end
        chk("flush_writes", 32'(nw), 3);
        chk("flush_write_order", 32'(bad_w), 0);
        chk("flush_stall_low", 32'(stall_low), 0);
        chk("flush_pulses", 32'(flushes), 1);
        chk("flush_cycle", 32'(flush_at), 5);

        // eoc with empty FIFO
        cyc(); eoc = 1;
        cyc(); eoc = 0; #1;
        chk("empty_flush_c1", 32'(flush_done), 0);
        cyc(); #1;
        chk("empty_flush_c2", 32'(flush_done), 1);
        cyc(); #1;
        chk("empty_flush_c3", 32'(flush_done), 0);

        // Reset while draining
        load_pending(3, 24);
        cyc(); core_weight_wrt = 0; eoc = 1;
        cyc(); eoc = 0; #1;
        chk("drain_stall", 32'(core_weight_stall), 1);
        chk("drain_pend", 32'(pend_count), 3);
        reset = 1; mem_weight_wrt = 0;
        cyc(); reset = 0; #1;
        chk("rst_drain_pend", 32'(pend_count), 0);
        chk("rst_drain_stall", 32'(core_weight_stall), 0);
        flushes = 0; nw = 0;
        for (int j = 0; j < 4; j++) begin
            if (flush_done) flushes++;
            if (ns_weight_wrt) nw++;
            cyc(); #1;
        end
        chk("rst_drain_no_flush", 32'(flushes), 0);
        chk("rst_drain_no_writes", 32'(nw), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_weight_port_arbiter.md
Name: pe_weight_port_arbiter

Overview:
Shares the single write port and single read port of a PE's weight namespace between three requesters: memory-side weight loads, PE-core weight write-back, and memory read-back. Core writes that lose arbitration to a memory load are buffered in a small pending FIFO rather than dropped. A flush FSM drains the FIFO on end-of-compute. The block sits between the PE memory interface and the weight namespace, inside the PE namespace wrapper.

Parameters:
peId, 0, global PE index; bits [(logNumPe+logNumPu)-1 -: logNumPeMemLanes] select the memory lane
logNumPe, 3, log2 PEs per PU
logNumPu, 3, log2 PUs
logNumPeMemLanes, 2, width of peId_mem_in
weightAddrLen, 5, weight namespace address width
dataLen, 16, weight data width
pendDepthLog, 2, log2 pending-FIFO depth (default 4 entries)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
eoc  in  1  end-of-compute pulse; starts flush
mem_weight_wrt  in  1  memory load write request
mem_weight_wrt_addr  in  weightAddrLen  memory load address
mem_weight_wrt_data  in  dataLen  memory load data
core_weight_wrt  in  1  PE core write-back request
core_weight_wrt_addr  in  weightAddrLen  core write address
core_weight_wrt_data  in  dataLen  core write data
core_weight_stall  out  1  core must not assert core_weight_wrt while high
mem_weight_rd_valid  in  1  read-back request on the lane bus
peId_mem_in  in  logNumPeMemLanes  lane targeted by read-back
weight_read_back_addr  in  weightAddrLen  read-back address
core_weight_rd_addr  in  weightAddrLen  core read address
ns_weight_wrt  out  1  namespace write enable
ns_weight_wrt_addr  out  weightAddrLen  namespace write address
ns_weight_wrt_data  out  dataLen  namespace write data
ns_weight_rd_addr  out  weightAddrLen  namespace read address
readback_v  out  1  namespace output holds read-back data (registered)
core_rd_blocked  out  1  core read displaced by read-back this cycle
core_rd_hazard  out  1  core read address matches a pending FIFO entry
pend_count  out  pendDepthLog+1  FIFO occupancy
overflow_err  out  1  sticky; a core write was offered while the FIFO was full
flush_done  out  1  one-cycle pulse when the flush completes

Behaviour:
- Reset values: FIFO pointers and count 0, readback_v 0, flush_done 0, overflow_err 0, state RUN. Reset mid-drain discards all pending entries.
- Write-port priority each cycle: mem_weight_wrt > FIFO head > direct core write. At most one ns write per cycle.
- Core write handling:
  - Core write with FIFO empty and no mem write: passes through combinationally in the same cycle and is not enqueued.
  - Otherwise the core write is enqueued.
  - A FIFO dequeue and an enqueue in the same cycle are both performed; count is unchanged.
- Ordering: FIFO contents drain in order. While the FIFO is non-empty, core writes always enqueue, so write ordering is preserved.
- core_weight_stall: combinational; equals FIFO full OR state != RUN.
- Overflow: a core write presented while the FIFO is full is dropped, and overflow_err is set. overflow_err clears only on reset.
- Read port:
  - lane_hit = mem_weight_rd_valid && lane bits of peId == peId_mem_in.
  - ns_weight_rd_addr = weight_read_back_addr when lane_hit, else core_weight_rd_addr.
  - core_rd_blocked = lane_hit.
  - readback_v <= lane_hit, giving 1-cycle latency to match the namespace read.
- core_rd_hazard: combinational OR over valid FIFO entries of (entry addr == core_weight_rd_addr).
- FSM:
  - RUN: on eoc go to DRAIN.
  - DRAIN: core stalled; FIFO drains whenever mem_weight_wrt is low. When count==0 (including on the first DRAIN cycle), go to DONE.
  - DONE: flush_done=1 for one cycle, then RUN.
  - eoc arriving in DRAIN or DONE is ignored.
- pend_count saturates at 2^pendDepthLog; read/write pointers wrap modulo the depth.

Test Plan:
- Core write addr 3 / data 0x00AA, FIFO empty, no mem write -> same cycle ns_weight_wrt=1, addr 3, data 0x00AA; pend_count stays 0.
- Mem write addr 1 and core write addr 2 in the same cycle -> ns writes addr 1; pend_count=1. Next cycle with no requests -> ns writes addr 2; pend_count=0.
- Hold mem_weight_wrt high 6 cycles while core writes every cycle, obeying stall:
  - core_weight_stall rises after 4 enqueues; overflow_err stays 0.
  - After mem drops, entries drain in order over 4 cycles.
  - Repeat ignoring stall -> overflow_err=1.
- peId=8 (lane bits 2'b00), peId_mem_in=0, mem_weight_rd_valid=1, read-back addr 7, core rd addr 4 -> ns_weight_rd_addr=7, core_rd_blocked=1, readback_v=1 next cycle. With peId_mem_in=1 -> ns_weight_rd_addr=4, readback_v=0.
- Enqueue pending entry addr 5 and set core_weight_rd_addr=5 -> core_rd_hazard=1; it drops to 0 the cycle after that entry is written.
- Three pending entries, pulse eoc:
  - Stall is high throughout.
  - FIFO drains in 3 cycles, then flush_done pulses once.
  - eoc with an empty FIFO -> flush_done two cycles after eoc.
  - reset asserted during DRAIN -> pend_count=0, state RUN, no flush_done.
